// File: rtl/mem_access.sv
// mem_access -- memory-access stage that sits directly after execute.
//
// Takes load/store requests from execute and runs them one at a time on a
// single-outstanding req/ack data bus, holding the pipeline with STALL until
// the transaction completes. Load data is lane-aligned, sign- or
// zero-extended, and presented for exactly one cycle on the REG_W_* port.
//
// Handshakes:
//   Upstream: a request is taken in IDLE on any cycle where MEM_R_VALID or
//     MEM_W_VALID is high. STALL is the "not ready" signal. It is high in that
//     IDLE cycle and throughout WRITE/READ, and low in DONE. Request inputs
//     are only looked at in IDLE.
//   Bus: BUS_REQ with its registered BUS_WE/BUS_ADDR/BUS_STRB/BUS_WDATA is the
//     "valid" side and stays stable until BUS_ACK is sampled high. BUS_ACK is
//     the "ready" side and BUS_RDATA is valid in the same cycle. BUS_ACK is
//     ignored while BUS_REQ is low. All bus fields are 0 whenever BUS_REQ=0.
//
// Optional feature (compile-time macro MEM_ACCESS_TIMEOUT_EN):
//   A wait counter aborts a bus transaction after TIMEOUT_CYCLES cycles
//   without an ack. The abort pulses ERR for one cycle, drops BUS_REQ,
//   discards any pending read and writes back rd=0/data=0. Without the
//   macro the block waits for ack indefinitely and ERR stays 0.
//
// Parameters:
//   TIMEOUT_CYCLES  bus-ack wait limit in cycles (timeout build only)
//
// Ports:
//   CLK, RST                      clock, asynchronous active-low reset
//   MEM_R_VALID/RD/ADDR/STRB/SIGNED  load request from execute
//   MEM_W_VALID/ADDR/STRB/DATA       store request from execute (lane-shifted)
//   STALL                         combinational pipeline hold
//   REG_W_RD, REG_W_DATA          one-cycle load writeback (0 when idle)
//   BUS_REQ/WE/ADDR/STRB/WDATA    registered bus request
//   BUS_ACK, BUS_RDATA            bus completion and read data
//   ERR                           one-cycle timeout pulse
//   DBG_STATE                     current FSM state (IDLE=0 WRITE=1 READ=2 DONE=3)

module mem_access #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        MEM_R_VALID,
  input  logic [4:0]  MEM_R_RD,
  input  logic [31:0] MEM_R_ADDR,
  input  logic [3:0]  MEM_R_STRB,
  input  logic        MEM_R_SIGNED,
  input  logic        MEM_W_VALID,
  input  logic [31:0] MEM_W_ADDR,
  input  logic [3:0]  MEM_W_STRB,
  input  logic [31:0] MEM_W_DATA,
  output logic        STALL,
  output logic [4:0]  REG_W_RD,
  output logic [31:0] REG_W_DATA,
  output logic        BUS_REQ,
  output logic        BUS_WE,
  output logic [31:0] BUS_ADDR,
  output logic [3:0]  BUS_STRB,
  output logic [31:0] BUS_WDATA,
  input  logic        BUS_ACK,
  input  logic [31:0] BUS_RDATA,
  output logic        ERR,
  output logic [1:0]  DBG_STATE
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_next;

  // Latched load request; needed after the write when R and W arrive together.
  logic        pend_r,   pend_r_next;
  logic [4:0]  r_rd,     r_rd_next;
  logic [31:0] r_addr,   r_addr_next;
  logic [3:0]  r_strb,   r_strb_next;
  logic        r_signed, r_signed_next;

  logic        bus_req_next;
  logic        bus_we_next;
  logic [31:0] bus_addr_next;
  logic [3:0]  bus_strb_next;
  logic [31:0] bus_wdata_next;

  logic [4:0]  reg_w_rd_next;
  logic [31:0] reg_w_data_next;
  logic        err_next;

  logic        timeout_hit;
  logic [31:0] load_result;

  // Align the addressed lane down to bit 0 and extend it to 32 bits.
  // The lowest set strobe bit gives the byte offset, the strobe popcount
  // gives the access width.
  function automatic logic [31:0] load_extend(input logic [31:0] rdata,
                                              input logic [3:0]  strb,
                                              input logic        sgn);
    logic [1:0]  off;
    logic [31:0] lane;
    logic [2:0]  width;
    logic [31:0] result;
    if (strb[0])      off = 2'd0;
    else if (strb[1]) off = 2'd1;
    else if (strb[2]) off = 2'd2;
    else if (strb[3]) off = 2'd3;
    else              off = 2'd0;
    lane  = rdata >> {off, 3'b000};
    width = 3'($countones(strb));
    case (width)
      3'd1:    result = {{24{sgn & lane[7]}}, lane[7:0]};
      3'd2:    result = {{16{sgn & lane[15]}}, lane[15:0]};
      default: result = lane;
    endcase
    return result;
  endfunction

  assign load_result = load_extend(BUS_RDATA, r_strb, r_signed);

  assign STALL = ((state == IDLE) && (MEM_R_VALID || MEM_W_VALID)) ||
                 (state == WRITE) || (state == READ);

  assign DBG_STATE = state;

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) < 8) ? 8 : $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             in_bus_state;

  assign in_bus_state = (state == WRITE) || (state == READ);

  // wait_cnt is 0 in the first cycle of a bus state, so the last cycle
  // allowed without an ack is the one where it reads TIMEOUT_CYCLES-1.
  assign timeout_hit = in_bus_state && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wait_cnt <= '0;
    end else if (state_next != state) begin
      wait_cnt <= '0;
    end else if (in_bus_state) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end
`else
  logic unused_timeout;

  assign timeout_hit    = 1'b0;
  assign unused_timeout = |TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_next      = state;
    pend_r_next     = pend_r;
    r_rd_next       = r_rd;
    r_addr_next     = r_addr;
    r_strb_next     = r_strb;
    r_signed_next   = r_signed;
    bus_req_next    = BUS_REQ;
    bus_we_next     = BUS_WE;
    bus_addr_next   = BUS_ADDR;
    bus_strb_next   = BUS_STRB;
    bus_wdata_next  = BUS_WDATA;
    reg_w_rd_next   = 5'd0;
    reg_w_data_next = 32'd0;
    err_next        = 1'b0;

    case (state)
      IDLE: begin
        if (MEM_W_VALID) begin
          state_next     = WRITE;
          bus_req_next   = 1'b1;
          bus_we_next    = 1'b1;
          bus_addr_next  = MEM_W_ADDR;
          bus_strb_next  = MEM_W_STRB;
          bus_wdata_next = MEM_W_DATA;
          if (MEM_R_VALID) begin
            pend_r_next   = 1'b1;
            r_rd_next     = MEM_R_RD;
            r_addr_next   = MEM_R_ADDR;
            r_strb_next   = MEM_R_STRB;
            r_signed_next = MEM_R_SIGNED;
          end
        end else if (MEM_R_VALID) begin
          state_next     = READ;
          r_rd_next      = MEM_R_RD;
          r_addr_next    = MEM_R_ADDR;
          r_strb_next    = MEM_R_STRB;
          r_signed_next  = MEM_R_SIGNED;
          bus_req_next   = 1'b1;
          bus_we_next    = 1'b0;
          bus_addr_next  = MEM_R_ADDR;
          bus_strb_next  = MEM_R_STRB;
          bus_wdata_next = 32'd0;
        end
      end

      WRITE: begin
        if (BUS_ACK) begin
          if (pend_r) begin
            // Chain straight into the read: BUS_REQ stays high across the
            // boundary and only the request fields change at the ack edge.
            state_next     = READ;
            pend_r_next    = 1'b0;
            bus_we_next    = 1'b0;
            bus_addr_next  = r_addr;
            bus_strb_next  = r_strb;
            bus_wdata_next = 32'd0;
          end else begin
            state_next     = DONE;
            bus_req_next   = 1'b0;
            bus_we_next    = 1'b0;
            bus_addr_next  = 32'd0;
            bus_strb_next  = 4'd0;
            bus_wdata_next = 32'd0;
          end
        end else if (timeout_hit) begin
          state_next     = DONE;
          pend_r_next    = 1'b0;
          err_next       = 1'b1;
          bus_req_next   = 1'b0;
          bus_we_next    = 1'b0;
          bus_addr_next  = 32'd0;
          bus_strb_next  = 4'd0;
          bus_wdata_next = 32'd0;
        end
      end

      READ: begin
        if (BUS_ACK) begin
          state_next      = DONE;
          reg_w_rd_next   = r_rd;
          reg_w_data_next = load_result;
          bus_req_next    = 1'b0;
          bus_we_next     = 1'b0;
          bus_addr_next   = 32'd0;
          bus_strb_next   = 4'd0;
          bus_wdata_next  = 32'd0;
        end else if (timeout_hit) begin
          // A timed-out load still occupies the DONE slot, with rd=0 so the
          // writeback is a no-op.
          state_next     = DONE;
          pend_r_next    = 1'b0;
          err_next       = 1'b1;
          bus_req_next   = 1'b0;
          bus_we_next    = 1'b0;
          bus_addr_next  = 32'd0;
          bus_strb_next  = 4'd0;
          bus_wdata_next = 32'd0;
        end
      end

      DONE: begin
        // Request inputs are deliberately ignored here; upstream sees
        // STALL=0 this cycle and presents its next request in IDLE.
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      pend_r     <= 1'b0;
      r_rd       <= 5'd0;
      r_addr     <= 32'd0;
      r_strb     <= 4'd0;
      r_signed   <= 1'b0;
      BUS_REQ    <= 1'b0;
      BUS_WE     <= 1'b0;
      BUS_ADDR   <= 32'd0;
      BUS_STRB   <= 4'd0;
      BUS_WDATA  <= 32'd0;
      REG_W_RD   <= 5'd0;
      REG_W_DATA <= 32'd0;
      ERR        <= 1'b0;
    end else begin
      state      <= state_next;
      pend_r     <= pend_r_next;
      r_rd       <= r_rd_next;
      r_addr     <= r_addr_next;
      r_strb     <= r_strb_next;
      r_signed   <= r_signed_next;
      BUS_REQ    <= bus_req_next;
      BUS_WE     <= bus_we_next;
      BUS_ADDR   <= bus_addr_next;
      BUS_STRB   <= bus_strb_next;
      BUS_WDATA  <= bus_wdata_next;
      REG_W_RD   <= reg_w_rd_next;
      REG_W_DATA <= reg_w_data_next;
      ERR        <= err_next;
    end
  end

endmodule
